sram_1rw_responder: RTL and testbench

// - Responder end of the 1-port SRAM request interface (enableRam/address/enableWrite/writeData -> readData).
// - Holds the storage array and returns read data with fixed 2-cycle latency, as the requestor-side coherency mux expects.
// - Clears the whole array after reset and stores one even-parity bit per word.
// - Flags and counts parity errors on read.

---
 rtl/sram_1rw_pkg.sv | 25 ++
 rtl/sram_1rw_responder_if.sv | 31 +++
 rtl/sram_1rw_array.sv | 30 +++
 rtl/sram_1rw_responder.sv | 124 ++++++++++++
 tb/tb_sram_1rw_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1rw_pkg.sv
// Shared types, FSM encodings and sizing helper for the 1RW SRAM responder.
package sram_1rw_pkg;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Address width for a given depth: ceil(log2(depth)), clamped to 1..14.
  function automatic int unsigned addr_width(input int unsigned depth);
    if (depth <= 2)         return 1;
    else if (depth <= 4)    return 2;
    else if (depth <= 8)    return 3;
    else if (depth <= 16)   return 4;
    else if (depth <= 32)   return 5;
    else if (depth <= 64)   return 6;
    else if (depth <= 128)  return 7;
    else if (depth <= 256)  return 8;
    else if (depth <= 512)  return 9;
    else if (depth <= 1024) return 10;
    else if (depth <= 2048) return 11;
    else if (depth <= 4096) return 12;
    else if (depth <= 8192) return 13;
    else                    return 14;
  endfunction

endpackage

// File: rtl/sram_1rw_responder_if.sv
// Request/response bundle between the SRAM requestor and this responder.
interface sram_1rw_responder_if
  import sram_1rw_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
);

  logic                     enableRam;
  logic [ADDR_WIDTH-1:0]    address;
  logic                     enableWrite;
  logic [RAM_WIDTH-1:0]     writeData;
  logic                     injectErr;
  logic [RAM_WIDTH-1:0]     readData;
  logic                     readValid;
  logic                     parityErr;
  logic [ERR_CNT_WIDTH-1:0] errCount;
  logic                     initDone;

  modport master (
    output enableRam, address, enableWrite, writeData, injectErr,
    input  readData, readValid, parityErr, errCount, initDone
  );

  modport slave (
    input  enableRam, address, enableWrite, writeData, injectErr,
    output readData, readValid, parityErr, errCount, initDone
  );

endinterface

// File: rtl/sram_1rw_array.sv
// Storage array: one write port, registered read port (read-first on collision).
module sram_1rw_array
  import sram_1rw_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WORD_WIDTH = 33,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clockCore,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [WORD_WIDTH-1:0] wrWord,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [WORD_WIDTH-1:0] rdWord
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Write commits and read samples the pre-write contents on the same edge.
  always_ff @(posedge clockCore) begin
    if (wrEn) begin
      mem[wrAddr] <= wrWord;
    end
    if (rdEn) begin
      rdWord <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/sram_1rw_responder.sv
// 1RW SRAM responder: post-reset clear, 2-cycle read latency, per-word even parity.
module sram_1rw_responder
  import sram_1rw_pkg::*;
#(
  parameter int unsigned RAM_DEPTH     = 16,
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic               clockCore,
  input  logic               resetCore,
  sram_1rw_responder_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = addr_width(RAM_DEPTH);
  localparam int unsigned WORD_WIDTH = RAM_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [0:0]            state;
  logic [0:0]            stateNext;
  logic [ADDR_WIDTH-1:0] initAddr;
  logic [ADDR_WIDTH-1:0] initAddrNext;

  logic                  inRange_c;
  logic                  accept_c;
  logic                  rdEn_c;
  logic                  wrEn_c;
  logic [ADDR_WIDTH-1:0] wrAddr_c;
  logic [WORD_WIDTH-1:0] wrWord_c;
  logic                  errHit_c;

  logic                  valid1;
  logic                  inRange1;
  logic [WORD_WIDTH-1:0] rdWord;

  // Request qualification: only after the clear has finished and only in range.
  assign inRange_c = (32'(bus.address) < RAM_DEPTH);
  assign accept_c  = bus.initDone & bus.enableRam;
  assign rdEn_c    = accept_c & inRange_c;

  // State register and clear-address counter.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      state    <= ST_INIT;
      initAddr <= '0;
    end else begin
      state    <= stateNext;
      initAddr <= initAddrNext;
    end
  end

  // Next state and write-port steering (clear writes in INIT, requests in READY).
  always_comb begin
    stateNext    = state;
    initAddrNext = initAddr;
    wrEn_c       = 1'b0;
    wrAddr_c     = bus.address;
    wrWord_c     = {(^bus.writeData) ^ bus.injectErr, bus.writeData};
    case (state)
      ST_INIT: begin
        wrEn_c   = 1'b1;
        wrAddr_c = initAddr;
        wrWord_c = '0;
        if (initAddr == LAST_ADDR) begin
          stateNext = ST_READY;
        end else begin
          initAddrNext = ADDR_WIDTH'(initAddr + 1'b1);
        end
      end
      default: begin
        wrEn_c = accept_c & bus.enableWrite & inRange_c;
      end
    endcase
  end

  sram_1rw_array #(
    .DEPTH      (RAM_DEPTH),
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uArray (
    .clockCore (clockCore),
    .wrEn      (wrEn_c),
    .wrAddr    (wrAddr_c),
    .wrWord    (wrWord_c),
    .rdEn      (rdEn_c),
    .rdAddr    (bus.address),
    .rdWord    (rdWord)
  );

  // Stage-1 control alongside the array's registered read.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      valid1   <= 1'b0;
      inRange1 <= 1'b0;
    end else begin
      valid1   <= accept_c;
      inRange1 <= inRange_c;
    end
  end

  // Stored parity bit XOR data parity is nonzero exactly on a mismatch.
  assign errHit_c = valid1 & inRange1 & (^rdWord);

  // Stage-2 outputs, parity flag, saturating error counter and init status.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      bus.readData  <= '0;
      bus.readValid <= 1'b0;
      bus.parityErr <= 1'b0;
      bus.errCount  <= '0;
      bus.initDone  <= 1'b0;
    end else begin
      bus.initDone  <= (state == ST_READY);
      bus.readValid <= valid1;
      bus.parityErr <= errHit_c;
      if (valid1) begin
        bus.readData <= inRange1 ? rdWord[RAM_WIDTH-1:0] : '0;
      end
      if (errHit_c && !(&bus.errCount)) begin
        bus.errCount <= ERR_CNT_WIDTH'(bus.errCount + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw_responder.sv
// Directed bench for sram_1rw_responder (depth 16 on busA, depth 12 on busB).
module tb_sram_1rw_responder;

  logic clockCore = 1'b0;
  logic resetCore = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sram_1rw_responder_if #(.ADDR_WIDTH(4), .RAM_WIDTH(32), .ERR_CNT_WIDTH(8)) busA ();
  sram_1rw_responder_if #(.ADDR_WIDTH(4), .RAM_WIDTH(32), .ERR_CNT_WIDTH(8)) busB ();

  sram_1rw_responder #(.RAM_DEPTH(16), .RAM_WIDTH(32), .ERR_CNT_WIDTH(8)) dutA (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .bus       (busA)
  );

  sram_1rw_responder #(.RAM_DEPTH(12), .RAM_WIDTH(32), .ERR_CNT_WIDTH(8)) dutB (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .bus       (busB)
  );

  always #5 clockCore = ~clockCore;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clockCore);
    #1;
  endtask

  task automatic drive(input bit onB, input logic en, input logic we, input logic [3:0] addr,
                       input logic [31:0] data, input logic inj);
    if (onB) begin
      busB.enableRam = en; busB.enableWrite = we; busB.address = addr;
      busB.writeData = data; busB.injectErr = inj;
    end else begin
      busA.enableRam = en; busA.enableWrite = we; busA.address = addr;
      busA.writeData = data; busA.injectErr = inj;
    end
  endtask

  task automatic idleAll();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  // One access cycle: drive, clock it in, return the bus to idle.
  task automatic access(input bit onB, input logic we, input logic [3:0] addr,
                        input logic [31:0] data, input logic inj);
    drive(onB, 1'b1, we, addr, data, inj);
    step();
    idleAll();
  endtask

  task automatic sample(input bit onB, output logic [31:0] d, output logic v,
                        output logic p, output logic [7:0] c);
    if (onB) begin
      d = busB.readData; v = busB.readValid; p = busB.parityErr; c = busB.errCount;
    end else begin
      d = busA.readData; v = busA.readValid; p = busA.parityErr; c = busA.errCount;
    end
  endtask

  task automatic readWord(input bit onB, input logic [3:0] addr, output logic [31:0] d,
                          output logic v, output logic p, output logic [7:0] c);
    access(onB, 1'b0, addr, 32'd0, 1'b0);
    step();
    sample(onB, d, v, p, c);
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    logic        p;
    logic [7:0]  c;
    int          n;

    // Reset values
    idleAll();
    resetCore = 1'b1;
    repeat (3) step();
    sample(1'b0, d, v, p, c);
    checkEq("rstReadData", 64'(d), 64'h0);
    checkEq("rstReadValid", 64'(v), 64'h0);
    checkEq("rstParityErr", 64'(p), 64'h0);
    checkEq("rstErrCount", 64'(c), 64'h0);
    checkEq("rstInitDone", 64'(busA.initDone), 64'h0);

    // Clear sequence: initDone low for 16 cycles, high on the 17th; requests ignored
    resetCore = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k >= 8 && k <= 10) drive(1'b0, 1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 1'b0);
      else idleAll();
      step();
      checkEq($sformatf("initLow%0d", k), 64'(busA.initDone), 64'h0);
      checkEq($sformatf("initNoValid%0d", k), 64'(busA.readValid), 64'h0);
    end
    idleAll();
    step();
    checkEq("initHighA", 64'(busA.initDone), 64'h1);
    checkEq("initHighB", 64'(busB.initDone), 64'h1);

    for (int a = 0; a < 16; a++) begin
      readWord(1'b0, 4'(a), d, v, p, c);
      checkEq($sformatf("clrValid%0d", a), 64'(v), 64'h1);
      checkEq($sformatf("clrData%0d", a), 64'(d), 64'h0);
      checkEq($sformatf("clrPerr%0d", a), 64'(p), 64'h0);
    end

    // Latency: write returns old data, read data appears exactly 2 cycles later
    access(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0);
    step();
    sample(1'b0, d, v, p, c);
    checkEq("wrRetValid", 64'(v), 64'h1);
    checkEq("wrRetOld", 64'(d), 64'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 4'd5, 32'd0, 1'b0);
    step();
    idleAll();
    checkEq("latT1Valid", 64'(busA.readValid), 64'h0);
    step();
    sample(1'b0, d, v, p, c);
    checkEq("latT2Valid", 64'(v), 64'h1);
    checkEq("latT2Data", 64'(d), 64'hDEAD_BEEF);
    checkEq("latT2Perr", 64'(p), 64'h0);
    step();
    sample(1'b0, d, v, p, c);
    checkEq("latT3Valid", 64'(v), 64'h0);
    checkEq("latT3Hold", 64'(d), 64'hDEAD_BEEF);

    // Read-first on a write collision
    access(1'b0, 1'b1, 4'd3, 32'h1111_1111, 1'b0);
    step();
    step();
    access(1'b0, 1'b1, 4'd3, 32'h2222_2222, 1'b0);
    step();
    sample(1'b0, d, v, p, c);
    checkEq("rfOldValid", 64'(v), 64'h1);
    checkEq("rfOldData", 64'(d), 64'h1111_1111);
    step();
    readWord(1'b0, 4'd3, d, v, p, c);
    checkEq("rfNewData", 64'(d), 64'h2222_2222);

    // Parity injection and saturating counter
    access(1'b0, 1'b1, 4'd7, 32'hA5A5_A5A5, 1'b1);
    step();
    step();
    readWord(1'b0, 4'd7, d, v, p, c);
    checkEq("parValid", 64'(v), 64'h1);
    checkEq("parErr1", 64'(p), 64'h1);
    checkEq("parCnt1", 64'(c), 64'h1);
    checkEq("parData", 64'(d), 64'hA5A5_A5A5);
    step();
    checkEq("parPulse", 64'(busA.parityErr), 64'h0);
    checkEq("parCntHold", 64'(busA.errCount), 64'h1);
    readWord(1'b0, 4'd7, d, v, p, c);
    checkEq("parCnt2", 64'(c), 64'h2);
    drive(1'b0, 1'b1, 1'b0, 4'd7, 32'd0, 1'b0);
    repeat (300) step();
    idleAll();
    step();
    step();
    checkEq("parCntSat", 64'(busA.errCount), 64'hFF);

    // Reset mid-operation, then again 4 cycles into the clear
    access(1'b0, 1'b1, 4'd9, 32'h0BAD_F00D, 1'b0);
    resetCore = 1'b1;
    step();
    resetCore = 1'b0;
    repeat (4) step();
    checkEq("midInitDone", 64'(busA.initDone), 64'h0);
    checkEq("midErrCount", 64'(busA.errCount), 64'h0);
    resetCore = 1'b1;
    step();
    resetCore = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (busA.initDone) begin
        n = i;
        break;
      end
    end
    checkEq("rstInitCycles", 64'(n), 64'd17);
    for (int a = 0; a < 16; a++) begin
      readWord(1'b0, 4'(a), d, v, p, c);
      checkEq($sformatf("reclrData%0d", a), 64'(d), 64'h0);
      checkEq($sformatf("reclrPerr%0d", a), 64'(p), 64'h0);
    end
    checkEq("reclrErrCount", 64'(busA.errCount), 64'h0);

    // Out-of-range on the depth-12 instance
    access(1'b1, 1'b1, 4'd1, 32'h1234_5678, 1'b0);
    step();
    step();
    access(1'b1, 1'b1, 4'd13, 32'hFFFF_FFFF, 1'b0);
    step();
    sample(1'b1, d, v, p, c);
    checkEq("oorWrValid", 64'(v), 64'h1);
    checkEq("oorWrData", 64'(d), 64'h0);
    step();
    readWord(1'b1, 4'd13, d, v, p, c);
    checkEq("oorRdValid", 64'(v), 64'h1);
    checkEq("oorRdData", 64'(d), 64'h0);
    checkEq("oorRdPerr", 64'(p), 64'h0);
    readWord(1'b1, 4'd1, d, v, p, c);
    checkEq("oorAddr1", 64'(d), 64'h1234_5678);
    checkEq("oorAddr1Perr", 64'(p), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
